// File: rtl/countdown_ctrl.sv
// Countdown timer controller: prescales clk into count ticks and sequences the
// digit chain through IDLE, RUN, PAUSE and DONE with registered ce/led/load strobes.
module countdown_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned CW       = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic pause_i,
  input  logic clear_i,
  input  logic zero_in_i,
  output logic ce_o,
  output logic led_o,
  output logic load_o,
  output logic running_o,
  output logic paused_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [CW-1:0] PCNT_MAX = CW'(TICK_DIV - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   pcnt_q, pcnt_d;
  logic            ce_q, ce_d;
  logic            led_q, led_d;
  logic            load_q, load_d;
  logic            tick;

  assign tick = (state_q == RUN) && (pcnt_q == PCNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      ce_q    <= 1'b0;
      led_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      ce_q    <= ce_d;
      led_q   <= led_d;
      load_q  <= load_d;
    end
  end

  // A pause on the tick edge parks the prescaler at its last value, so the
  // first RUN edge after resuming is itself a tick edge.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    ce_d    = 1'b0;
    led_d   = 1'b0;
    load_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      pcnt_d  = '0;
      load_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          pcnt_d = '0;
          if (start_i) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            if (pause_i) begin
              state_d = PAUSE;
            end else if (zero_in_i) begin
              state_d = DONE;
              led_d   = 1'b1;
              pcnt_d  = '0;
            end else begin
              ce_d   = 1'b1;
              pcnt_d = '0;
            end
          end else begin
            pcnt_d = pcnt_q + 1'b1;
            if (pause_i) state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (start_i || pause_i) state_d = RUN;
        end
        DONE: begin
          led_d  = 1'b1;
          pcnt_d = '0;
        end
        default: begin
          state_d = IDLE;
          pcnt_d  = '0;
        end
      endcase
    end
  end

  assign ce_o      = ce_q;
  assign led_o     = led_q;
  assign load_o    = load_q;
  assign running_o = (state_q == RUN);
  assign paused_o  = (state_q == PAUSE);

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per count tick; legal range >= 2.
REQ-002 Parameter CW, default 27, prescaler width; SHALL satisfy 2**CW >= TICK_DIV.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begin or resume counting.
REQ-006 pause  input  1  one-cycle pulse; freeze counting (RUN) or resume (PAUSE).
REQ-007 clear  input  1  one-cycle pulse; abort, reload digit chain, return to IDLE.
REQ-008 zero_in  input  1  high while every digit of the downstream chain reads 0.
REQ-009 ce  output  1  registered single-cycle count-enable pulse to the least-significant digit.
REQ-010 led  output  1  registered; high while timer expired; drives the digit chain's clear-to-zero input.
REQ-011 load  output  1  registered one-cycle pulse; drives the digit chain's reload input.
REQ-012 running  output  1  high in RUN.
REQ-013 paused  output  1  high in PAUSE.

Function
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE, DONE; one-hot or binary at implementer's choice.
REQ-015 Prescaler pcnt (CW bits) SHALL increment each cycle in RUN and wrap TICK_DIV-1 -> 0; held in PAUSE; forced to 0 in IDLE and DONE.
REQ-016 IDLE: start -> RUN with pcnt = 0; pause ignored.
REQ-017 RUN, edge where pcnt == TICK_DIV-1 and zero_in = 0: ce = 1 for the following cycle only, pcnt -> 0.
REQ-018 RUN, edge where pcnt == TICK_DIV-1 and zero_in = 1: -> DONE, led = 1, ce stays 0.
REQ-019 zero_in SHALL be sampled only at the tick edge; zero_in changes between ticks have no effect.
REQ-020 RUN: pause -> PAUSE; pause on the tick edge wins, no ce, pcnt held at TICK_DIV-1.
REQ-021 PAUSE: start or pause -> RUN; pcnt resumes from held value, so total RUN cycles between ces equal TICK_DIV.
REQ-022 DONE: led held 1; start and pause ignored; only clear or reset leave DONE.
REQ-023 clear in any state: -> IDLE, pcnt = 0, ce = 0, led = 0, load = 1 for exactly the next cycle.
REQ-024 Priority per edge: reset > clear > tick-expire/pause > start.
REQ-025 start in RUN SHALL be ignored (no prescaler restart).
REQ-026 First ce after start SHALL be high during the cycle following the TICK_DIV-th rising edge after the edge that sampled start; subsequent ces every TICK_DIV cycles.
REQ-027 ce SHALL never be asserted outside the cycle following a RUN tick edge; ce and led SHALL never be high together.
REQ-028 running and paused SHALL be decoded directly from state, never both high.

Reset
REQ-029 reset (sampled high on an edge) SHALL force IDLE, pcnt = 0, ce = 0, led = 0, load = 0, regardless of other inputs.
REQ-030 reset mid-RUN or mid-PAUSE SHALL discard the held prescaler value; next start counts a full TICK_DIV.
REQ-031 load SHALL NOT be driven by reset; digit chain is reset by the same reset net.

Verification (TICK_DIV = 4)
REQ-032 reset, then start at edge 0, zero_in = 0 -> ce high after edges 4, 8, 12 only; running = 1.
REQ-033 RUN, pause at edge 2 after start, pause again 10 cycles later -> no ce during PAUSE; next ce after 2 further RUN edges (edge 4 of RUN time).
REQ-034 RUN, zero_in = 1 at tick edge -> led = 1 from next cycle, ce = 0, state DONE; start/pause pulses keep led = 1.
REQ-035 DONE, clear -> led = 0, load = 1 for one cycle, then IDLE; next start restarts full 4-cycle tick.
REQ-036 RUN with pcnt = 3, pause and clear on same edge -> IDLE, load = 1, no ce; reset asserted with start on same edge -> IDLE, all outputs 0.
